// File: rtl/control_incendio_seq_pkg.sv
// rtl/control_incendio_seq_pkg.sv - shared constants for the fire-control sequencer
package control_incendio_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALERTA = 2'd1,
        ACTIVO = 2'd2,
        PURGA  = 2'd3
    } estado_t;

    localparam logic PAT_A = 1'b0;
    localparam logic PAT_B = 1'b1;

    localparam int unsigned T_ALERTA_DEF = 5;
    localparam int unsigned T_PURGA_DEF  = 10;

    localparam logic [10:0] SALIDA_RST = 11'h7FF;

endpackage

// File: rtl/control_incendio_seq_temporizador_seg.sv
// rtl/control_incendio_seq_temporizador_seg.sv - saturating seconds counter for state timing
module temporizador_seg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       tick,
    output logic [7:0] count
);

    // Count enabled ticks; clear wins, and the count holds at 255 instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= 8'd0;
        end else if (en && tick && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/control_incendio_seq.sv
// rtl/control_incendio_seq.sv - fire-suppression sequencer with pattern-memory actuator output
module control_incendio_seq
    import control_incendio_seq_pkg::*;
#(
    parameter int unsigned T_ALERTA = T_ALERTA_DEF,
    parameter int unsigned T_PURGA  = T_PURGA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1s,
    input  logic        humo,
    input  logic        temp_alta,
    input  logic        paro,
    output logic        mem_adress,
    input  logic [10:0] mem_data,
    output logic [10:0] salida,
    output logic        alarma,
    output logic [1:0]  estado
);

    localparam logic [8:0] TA9 = 9'(T_ALERTA);
    localparam logic [8:0] TP9 = 9'(T_PURGA);

    estado_t    state;
    estado_t    state_next;
    logic       evento;
    logic [7:0] count;
    logic [8:0] count_inc;
    logic       tmr_clr;
    logic       tmr_en;

    assign evento    = humo | temp_alta;
    assign count_inc = {1'b0, count} + 9'd1;
    assign tmr_clr   = (state_next != state);
    assign tmr_en    = (state == ALERTA) || (state == PURGA);

    temporizador_seg u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tick  (tick_1s),
        .count (count)
    );

    // Next-state rules; manual stop overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (evento) state_next = ALERTA;
            end
            ALERTA: begin
                if (!evento)                               state_next = IDLE;
                else if (tick_1s && (count_inc == TA9))    state_next = ACTIVO;
            end
            ACTIVO: begin
                if (!evento) state_next = PURGA;
            end
            PURGA: begin
                if (evento)                                state_next = ACTIVO;
                else if (tick_1s && (count_inc == TP9))    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (paro) state_next = IDLE;
    end

    // Memory address follows the current state directly
    always_comb begin
        mem_adress = (state == ACTIVO) ? PAT_B : PAT_A;
    end

    // State, alarm flag and actuator word all update on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            alarma <= 1'b0;
            salida <= SALIDA_RST;
        end else begin
            state  <= state_next;
            alarma <= (state_next != IDLE);
            salida <= mem_data;
        end
    end

    assign estado = state;

endmodule
